// File: rtl/msg_dispatch_if.sv
// Arbiter-to-dispatcher message stream plus per-cache output ports.
interface msg_dispatch_if #(
  parameter int CACHE_NUM = 4,
  parameter int MSG_W     = 40
);
  logic                       msg_in_valid;
  logic [MSG_W-1:0]           msg_in;
  logic                       msg_in_ready;
  logic [CACHE_NUM-1:0]       msg_out_valid;
  logic [CACHE_NUM*MSG_W-1:0] msg_out;
  logic [CACHE_NUM-1:0]       msg_out_ready;
  logic                       drop_err;

  modport master (
    output msg_in_valid, msg_in, msg_out_ready,
    input  msg_in_ready, msg_out_valid, msg_out, drop_err
  );

  modport slave (
    input  msg_in_valid, msg_in, msg_out_ready,
    output msg_in_ready, msg_out_valid, msg_out, drop_err
  );
endinterface

// File: rtl/msg_dispatch.sv
// Coherence message dispatcher: decodes dst, fans out broadcasts,
// and queues each cache's messages in its own small FIFO.
module msg_dispatch #(
  parameter int CACHE_NUM = 4,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = (CACHE_NUM > 1 ? $clog2(CACHE_NUM) : 1),
  parameter int MSG_W     = 4 + 2*ID_W + ADDR_W,
  parameter int DEPTH     = 2
) (
  input logic           clk,
  input logic           rst,
  msg_dispatch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [MSG_W-1:0] mem [CACHE_NUM][DEPTH];
  logic [PW-1:0]    wp  [CACHE_NUM];
  logic [PW-1:0]    rp  [CACHE_NUM];
  logic [CW-1:0]    cnt [CACHE_NUM];

  logic             bcast;
  logic [ID_W-1:0]  src;
  logic [ID_W-1:0]  dst;
  logic             bad;
  logic             ok;
  logic             acc;
  logic [CACHE_NUM-1:0] mask;
  logic [CACHE_NUM-1:0] push;
  logic [CACHE_NUM-1:0] pop;
  logic             drop_q;

  assign bcast = bus.msg_in[MSG_W-1];
  assign src   = bus.msg_in[ADDR_W+ID_W +: ID_W];
  assign dst   = bus.msg_in[ADDR_W +: ID_W];
  assign bad   = !bcast && (32'(dst) >= 32'(CACHE_NUM));

  // Readiness uses the registered counts only; a pop never frees
  // space for the same cycle's push.
  always_comb begin
    mask = '0;
    ok   = 1'b1;
    for (int i = 0; i < CACHE_NUM; i++) begin
      if (bcast) mask[i] = (ID_W'(i) != src);
      else       mask[i] = (ID_W'(i) == dst);
      if (mask[i] && cnt[i] == CW'(DEPTH)) ok = 1'b0;
    end
  end

  assign bus.msg_in_ready = rst ? !bus.msg_in_valid : ok;
  assign acc = bus.msg_in_valid && ok && !rst;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < CACHE_NUM; i++) begin
      push[i] = acc && mask[i];
      pop[i]  = bus.msg_out_ready[i] && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 1'b0;
      for (int i = 0; i < CACHE_NUM; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        cnt[i] <= '0;
        for (int j = 0; j < DEPTH; j++) mem[i][j] <= '0;
      end
    end else begin
      drop_q <= acc && bad;
      for (int i = 0; i < CACHE_NUM; i++) begin
        if (push[i]) begin
          mem[i][wp[i]] <= bus.msg_in;
          wp[i] <= wp[i] + PW'(1);
        end
        if (pop[i]) rp[i] <= rp[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  assign bus.drop_err = drop_q;

  for (genvar g = 0; g < CACHE_NUM; g++) begin : g_out
    assign bus.msg_out_valid[g]            = (cnt[g] != '0);
    assign bus.msg_out[g*MSG_W +: MSG_W]   = mem[g][rp[g]];
  end
endmodule

// File: tb/tb_msg_dispatch.sv
// Bench for msg_dispatch: 4-port and 3-port instances driven in
// lockstep and compared against per-port message queues.
module tb_msg_dispatch;
  logic clk;
  logic rst;

  msg_dispatch_if #(.CACHE_NUM(4), .MSG_W(40)) b4();
  msg_dispatch_if #(.CACHE_NUM(3), .MSG_W(40)) b3();

  msg_dispatch #(.CACHE_NUM(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  msg_dispatch #(.CACHE_NUM(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [39:0] q [2][4][$];
  logic        dexp [2];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ports(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic [3:0] targets(input int d, input logic [39:0] m);
    logic [3:0] t;
    int s, x;
    t = '0;
    s = int'(m[35:34]);
    x = int'(m[33:32]);
    for (int i = 0; i < ports(d); i++)
      t[i] = m[39] ? (i != s) : (i == x);
    return t;
  endfunction

  function automatic logic room(input int d, input logic [39:0] m);
    logic [3:0] t;
    t = targets(d, m);
    for (int i = 0; i < ports(d); i++)
      if (t[i] && q[d][i].size() >= 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [39:0] slice(input int d, input int i);
    return (d == 0) ? b4.msg_out[i*40 +: 40] : b3.msg_out[i*40 +: 40];
  endfunction

  function automatic logic got_rdy(input int d);
    return (d == 0) ? b4.msg_in_ready : b3.msg_in_ready;
  endfunction

  function automatic logic got_drop(input int d);
    return (d == 0) ? b4.drop_err : b3.drop_err;
  endfunction

  function automatic logic got_vld(input int d, input int i);
    return (d == 0) ? b4.msg_out_valid[i] : b3.msg_out_valid[i];
  endfunction

  task automatic cycle(input logic r, input logic v,
                       input logic [39:0] m, input logic [3:0] rd);
    logic er, acc;
    logic [3:0] t;
    @(negedge clk);
    rst = r;
    b4.msg_in_valid  = v;  b3.msg_in_valid  = v;
    b4.msg_in        = m;  b3.msg_in        = m;
    b4.msg_out_ready = rd; b3.msg_out_ready = rd[2:0];
    #1;
    for (int d = 0; d < 2; d++) begin
      er = r ? !v : room(d, m);
      check($sformatf("ready%0d", d), 64'(got_rdy(d)), 64'(er));
      if (!r) begin
        check($sformatf("drop%0d", d), 64'(got_drop(d)), 64'(dexp[d]));
        for (int i = 0; i < ports(d); i++) begin
          check($sformatf("valid%0d_%0d", d, i), 64'(got_vld(d, i)),
                64'(q[d][i].size() != 0));
          if (q[d][i].size() != 0)
            check($sformatf("head%0d_%0d", d, i), 64'(slice(d, i)),
                  64'(q[d][i][0]));
        end
      end
      acc = !r && v && er;
      t = targets(d, m);
      if (r) begin
        dexp[d] = 1'b0;
        for (int i = 0; i < 4; i++) q[d][i].delete();
      end else begin
        dexp[d] = acc && !m[39] && (int'(m[33:32]) >= ports(d));
        for (int i = 0; i < ports(d); i++)
          if (rd[i] && q[d][i].size() != 0) void'(q[d][i].pop_front());
        for (int i = 0; i < ports(d); i++)
          if (acc && t[i]) q[d][i].push_back(m);
      end
    end
  endtask

  function automatic logic [39:0] mk(input logic [3:0] ty, input logic [1:0] s,
                                     input logic [1:0] x, input logic [31:0] a);
    return {ty, s, x, a};
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, 4'hF);
  endtask

  logic [39:0] m1, mb, ma, mbb, mc, bc0, d0, d1, d2, bad3;
  logic [63:0] rr;

  initial begin
    n_chk = 0;
    n_fail = 0;
    dexp[0] = 1'b0;
    dexp[1] = 1'b0;
    rst = 1'b1;
    b4.msg_in_valid = 1'b0; b3.msg_in_valid = 1'b0;
    b4.msg_in = '0;         b3.msg_in = '0;
    b4.msg_out_ready = '0;  b3.msg_out_ready = '0;

    cycle(1'b1, 1'b0, '0, 4'h0);
    cycle(1'b1, 1'b0, '0, 4'h0);
    cycle(1'b0, 1'b0, '0, 4'hF);
    check("rst_valid", 64'(b4.msg_out_valid), 64'h0);
    check("rst_out", 64'(b4.msg_out[63:0]), 64'h0);
    check("rst_drop", 64'(b4.drop_err), 64'h0);

    m1 = mk(4'h1, 2'd0, 2'd2, 32'h1000_0040);
    cycle(1'b0, 1'b1, m1, 4'hF);
    cycle(1'b0, 1'b0, '0, 4'hF);
    check("uni_valid", 64'(b4.msg_out_valid), 64'(4'b0100));
    check("uni_data", 64'(b4.msg_out[80 +: 40]), 64'(m1));
    cycle(1'b0, 1'b0, '0, 4'hF);
    check("uni_gone", 64'(b4.msg_out_valid), 64'h0);

    mb = mk(4'h8, 2'd1, 2'd0, 32'hA0);
    cycle(1'b0, 1'b1, mb, 4'hF);
    cycle(1'b0, 1'b0, '0, 4'hF);
    check("bc_valid", 64'(b4.msg_out_valid), 64'(4'b1101));
    check("bc_s0", 64'(b4.msg_out[0 +: 40]), 64'(mb));
    check("bc_s3", 64'(b4.msg_out[120 +: 40]), 64'(mb));
    idle(2);

    ma  = mk(4'h2, 2'd1, 2'd3, 32'hAAAA_0000);
    mbb = mk(4'h2, 2'd1, 2'd3, 32'hBBBB_0000);
    mc  = mk(4'h2, 2'd1, 2'd3, 32'hCCCC_0000);
    bc0 = mk(4'h9, 2'd0, 2'd0, 32'h0000_0B0C);
    cycle(1'b0, 1'b1, ma, 4'b0111);
    cycle(1'b0, 1'b1, mbb, 4'b0111);
    cycle(1'b0, 1'b1, mc, 4'b0111);
    check("bp_third", 64'(b4.msg_in_ready), 64'h0);
    cycle(1'b0, 1'b1, bc0, 4'b0111);
    check("bp_bcast", 64'(b4.msg_in_ready), 64'h0);
    cycle(1'b0, 1'b1, bc0, 4'hF);
    check("bp_nobypass", 64'(b4.msg_in_ready), 64'h0);
    check("bp_headA", 64'(b4.msg_out[120 +: 40]), 64'(ma));
    cycle(1'b0, 1'b1, bc0, 4'hF);
    check("bp_release", 64'(b4.msg_in_ready), 64'h1);
    check("bp_headB", 64'(b4.msg_out[120 +: 40]), 64'(mbb));
    idle(4);

    d0 = mk(4'h3, 2'd2, 2'd0, 32'hD000_0000);
    d1 = mk(4'h3, 2'd2, 2'd0, 32'hD000_0001);
    d2 = mk(4'h3, 2'd2, 2'd0, 32'hD000_0002);
    cycle(1'b0, 1'b1, d0, 4'b1110);
    cycle(1'b0, 1'b1, d1, 4'b1110);
    cycle(1'b0, 1'b1, d2, 4'hF);
    check("full_pop", 64'(b4.msg_in_ready), 64'h0);
    cycle(1'b0, 1'b1, d2, 4'hF);
    check("full_next", 64'(b4.msg_in_ready), 64'h1);
    idle(4);

    bad3 = mk(4'h4, 2'd0, 2'd3, 32'hDEAD_0000);
    cycle(1'b0, 1'b1, bad3, 4'hF);
    check("bad_ready", 64'(b3.msg_in_ready), 64'h1);
    cycle(1'b0, 1'b0, '0, 4'hF);
    check("bad_drop", 64'(b3.drop_err), 64'h1);
    check("bad_novalid", 64'(b3.msg_out_valid), 64'h0);
    cycle(1'b0, 1'b0, '0, 4'hF);
    check("bad_pulse", 64'(b3.drop_err), 64'h0);

    cycle(1'b0, 1'b1, bc0, 4'h0);
    cycle(1'b0, 1'b1, bc0, 4'h0);
    cycle(1'b0, 1'b1, d0, 4'h0);
    cycle(1'b0, 1'b1, d1, 4'h0);
    cycle(1'b1, 1'b1, d2, 4'h0);
    cycle(1'b0, 1'b0, '0, 4'h0);
    check("mid_valid", 64'(b4.msg_out_valid), 64'h0);
    check("mid_out_lo", 64'(b4.msg_out[63:0]), 64'h0);
    check("mid_out_hi", 64'(b4.msg_out[159:96]), 64'h0);
    cycle(1'b0, 1'b1, m1, 4'h0);
    cycle(1'b0, 1'b0, '0, 4'h0);
    check("post_valid", 64'(b4.msg_out_valid), 64'(4'b0100));
    check("post_data", 64'(b4.msg_out[80 +: 40]), 64'(m1));
    idle(3);

    for (int k = 0; k < 3000; k++) begin
      rr = {$urandom(), $urandom()};
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            rr[39:0], 4'($urandom()));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
